score_scan_ctrl: RTL and testbench



---
 rtl/score_scan_ctrl_if.sv | 28 ++
 rtl/score_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_score_scan_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/score_scan_ctrl_if.sv
// Bus between the score sequencer and its client: load request, score value,
// busy status and the shared segment-decoder / anode drive.
interface score_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
);
    logic [BIN_W-1:0]      value_in;
    logic                  load;
    logic                  busy;
    logic [3:0]            digit_code;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output value_in,
        output load,
        input  busy,
        input  digit_code,
        input  an
    );

    modport slave (
        input  value_in,
        input  load,
        output busy,
        output digit_code,
        output an
    );
endinterface

// File: rtl/score_scan_ctrl.sv
// Score display sequencer: multi-cycle binary-to-BCD conversion into a display
// register, plus digit scanning with leading-zero blanking for a 7-segment mux.
module score_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic               clk,
    input  logic               reset,
    score_scan_ctrl_if.slave   bus
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     r_disp;
    logic [CNT_W-1:0]     r_iter;
    logic [PRE_W-1:0]     r_presc;
    logic [IDX_W-1:0]     r_idx;

    logic [BIN_W-1:0]     w_cap;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     w_shifted;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                 w_blank;
    logic                 w_busy;
    logic [3:0]           w_digit;
    logic [NUM_DIGITS-1:0] w_an;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.load) w_state_nxt = SHIFT;
            SHIFT:   if (r_iter == CNT_W'(1)) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state != IDLE) w_busy = 1'b1;
    end

    // Out-of-range scores clamp to the largest displayable value
    always_comb begin
        w_cap = bus.value_in;
        if (32'(bus.value_in) > MAX_VAL) w_cap = BIN_W'(MAX_VAL);
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
    end

    // Conversion datapath and display register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_disp <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_bin  <= w_cap;
                        r_bcd  <= '0;
                        r_iter <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_iter         <= r_iter - CNT_W'(1);
                end
                COMMIT:  r_disp <= r_bcd;
                default: ;
            endcase
        end
    end

    // Free-running scan prescaler and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) r_idx <= '0;
            else                                 r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Digit select and blanking: a digit is dark when it and all above it are zero
    always_comb begin
        w_shifted = r_disp >> {r_idx, 2'b00};
        w_onehot  = NUM_DIGITS'(1) << r_idx;
        w_blank   = (r_idx != '0) && (w_shifted == '0);
        w_digit   = w_shifted[3:0];
        w_an      = w_blank ? '1 : ~w_onehot;
    end

    assign bus.busy       = w_busy;
    assign bus.digit_code = w_digit;
    assign bus.an         = w_an;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Randomized + directed bench for score_scan_ctrl against an arithmetic model
// of conversion latency, saturation, scan timing and blanking.
module tb_score_scan_ctrl;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned MAX_VAL    = 9999;
    localparam int unsigned CONV_CYC   = BIN_W + 1;

    logic clk;
    logic reset;
    logic chk_en;

    int n_vec;
    int n_err;

    int m_ticks;
    int m_busy_left;
    int m_pending;
    int m_disp;

    score_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) bus ();

    score_scan_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: busy countdown, pending value, ticks since reset release
    always @(posedge clk) begin
        if (reset) begin
            m_ticks     = 0;
            m_busy_left = 0;
            m_disp      = 0;
        end else begin
            m_ticks++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_disp = m_pending;
            end else if (bus.load) begin
                m_pending   = (int'(bus.value_in) > int'(MAX_VAL)) ? int'(MAX_VAL) : int'(bus.value_in);
                m_busy_left = int'(CONV_CYC);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            int p;
            int dig;
            logic [3:0] an_exp;
            idx = (m_ticks / int'(SCAN_DIV)) % int'(NUM_DIGITS);
            p = 1;
            for (int i = 0; i < idx; i++) p = p * 10;
            dig = (m_disp / p) % 10;
            if (idx > 0 && m_disp < p) an_exp = 4'hF;
            else                       an_exp = ~(4'b0001 << idx);
            chk("busy", 32'(bus.busy), 32'(m_busy_left > 0));
            chk("digit_code", 32'(bus.digit_code), 32'(dig));
            chk("an", 32'(bus.an), 32'(an_exp));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        bus.value_in = BIN_W'(v);
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        chk_en       = 1'b0;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;
        idle(2);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(20);

        do_load(1234);  idle(40);
        do_load(7);     idle(20);
        do_load(1005);  idle(40);
        do_load(16383); idle(20);
        do_load(10000); idle(20);
        do_load(9999);  idle(20);

        // second load lands while busy and must be dropped
        do_load(42);    idle(2);
        do_load(99);    idle(30);
        do_load(0);     idle(20);

        // reset partway through a conversion
        do_load(1234);  idle(20);
        do_load(56);    idle(4);
        reset = 1'b1;   idle(1);
        reset = 1'b0;   idle(5);
        do_load(56);    idle(40);

        // load coincident with reset is ignored
        do_load(1234);  idle(20);
        reset = 1'b1;
        do_load(4321);
        reset = 1'b0;   idle(25);

        for (int i = 0; i < 600; i++) begin
            bus.value_in = BIN_W'($urandom_range(0, 16383));
            bus.load     = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        bus.load = 1'b0;
        reset    = 1'b0;
        idle(30);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
